// File: rtl/header_extractor_pkg.sv
// Shared constants and types for the Ethernet/IPv4 5-tuple extractor.
// Byte offsets are absolute positions from the first byte of the Ethernet frame.
package header_extractor_pkg;

    localparam logic [7:0] OFF_ETYPE  = 8'd12;
    localparam logic [7:0] OFF_VIHL   = 8'd14;
    localparam logic [7:0] OFF_FRAG   = 8'd20;
    localparam logic [7:0] OFF_PROTO  = 8'd23;
    localparam logic [7:0] OFF_SA     = 8'd26;
    localparam logic [7:0] OFF_DA     = 8'd30;
    localparam logic [7:0] OFF_DA_END = 8'd33;

    localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  PROTO_TCP  = 8'h06;
    localparam logic [7:0]  PROTO_UDP  = 8'h11;

    localparam logic ST_PARSE = 1'b0;
    localparam logic ST_DRAIN = 1'b1;

    // Byte i of fields_t (bits [8i+:8]) is enabled by bit i of field_en_t.
    typedef struct packed {
        logic [15:0] etype;
        logic [7:0]  vihl;
        logic [15:0] frag;
        logic [7:0]  proto;
        logic [31:0] sa;
        logic [31:0] da;
        logic [31:0] ports;
    } fields_t;

    typedef struct packed {
        logic [1:0] etype;
        logic       vihl;
        logic [1:0] frag;
        logic       proto;
        logic [3:0] sa;
        logic [3:0] da;
        logic [3:0] ports;
    } field_en_t;

    function automatic logic [7:0] l4_offset(input logic [3:0] ihl);
        return 8'd14 + {2'b00, ihl, 2'b00};
    endfunction

    function automatic fields_t merge_fields(input fields_t q, input fields_t b, input field_en_t en);
        fields_t m;
        m = q;
        for (int i = 0; i < 18; i++) begin
            if (en[i]) m[8*i +: 8] = b[8*i +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/header_extractor_capture.sv
// Maps the 8 byte lanes of one beat onto the header fields they cover.
// Produces per-field byte enables and the lane data placed at the field's byte position.
module hdr_byte_capture
    import header_extractor_pkg::*;
(
    input  logic [63:0] tdata,
    input  logic [7:0]  base,
    input  logic [7:0]  l4_off,
    output fields_t     cap_data,
    output field_en_t   cap_en
);

    always_comb begin
        cap_data = '0;
        cap_en   = '0;
        for (int k = 0; k < 8; k++) begin
            if (base + 8'(k) == OFF_VIHL) begin
                cap_en.vihl   = 1'b1;
                cap_data.vihl = tdata[63-8*k -: 8];
            end
            if (base + 8'(k) == OFF_PROTO) begin
                cap_en.proto   = 1'b1;
                cap_data.proto = tdata[63-8*k -: 8];
            end
            for (int j = 0; j < 2; j++) begin
                if (base + 8'(k) == OFF_ETYPE + 8'(j)) begin
                    cap_en.etype[1-j]          = 1'b1;
                    cap_data.etype[15-8*j -: 8] = tdata[63-8*k -: 8];
                end
                if (base + 8'(k) == OFF_FRAG + 8'(j)) begin
                    cap_en.frag[1-j]          = 1'b1;
                    cap_data.frag[15-8*j -: 8] = tdata[63-8*k -: 8];
                end
            end
            // Ports sit at an IHL-dependent offset supplied by the top.
            for (int j = 0; j < 4; j++) begin
                if (base + 8'(k) == OFF_SA + 8'(j)) begin
                    cap_en.sa[3-j]          = 1'b1;
                    cap_data.sa[31-8*j -: 8] = tdata[63-8*k -: 8];
                end
                if (base + 8'(k) == OFF_DA + 8'(j)) begin
                    cap_en.da[3-j]          = 1'b1;
                    cap_data.da[31-8*j -: 8] = tdata[63-8*k -: 8];
                end
                if (base + 8'(k) == l4_off + 8'(j)) begin
                    cap_en.ports[3-j]          = 1'b1;
                    cap_data.ports[31-8*j -: 8] = tdata[63-8*k -: 8];
                end
            end
        end
    end

endmodule

// File: rtl/header_extractor.sv
// Parses Ethernet/IPv4 frames from an AXI4-Stream and emits one 5-tuple per accepted frame
// through a one-entry output register, counting emitted headers and dropped frames.
module header_extractor
    import header_extractor_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WIDTH  = 104,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [HDR_WIDTH-1:0]  hdr,
    output logic                  hdr_valid,
    input  logic                  hdr_ready,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    logic                 state_q, state_d;
    logic [3:0]           beat_idx_q, beat_idx_d;
    fields_t              fld_q, fld_d, fld_m, cap_data;
    field_en_t            cap_en;
    logic [HDR_WIDTH-1:0] hdr_q, hdr_d;
    logic                 hdr_valid_q, hdr_valid_d;
    logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;

    logic       accept, parse_beat, qual_ok, bad_qual, want_ports, tuple_done, load, drop;
    logic [7:0] base, last_byte, l4_off;

    assign base   = {1'b0, beat_idx_q, 3'b000};
    assign l4_off = l4_offset(fld_m.vihl[3:0]);

    hdr_byte_capture u_capture (
        .tdata    (s_axis_tdata),
        .base     (base),
        .l4_off   (l4_off),
        .cap_data (cap_data),
        .cap_en   (cap_en)
    );

    // A full output entry that is not being consumed this cycle stalls the input.
    assign s_axis_tready = !(hdr_valid_q && !hdr_ready);

    always_comb begin
        accept     = s_axis_tvalid && s_axis_tready;
        parse_beat = accept && (state_q == ST_PARSE);
        fld_m      = merge_fields(fld_q, cap_data, cap_en);
        last_byte  = base + 8'd7;
        qual_ok    = (fld_m.etype == ETYPE_IPV4) && (fld_m.vihl[7:4] == 4'd4) && (fld_m.vihl[3:0] >= 4'd5);
        // All qualification bytes (12..14) arrive together in beat 1.
        bad_qual   = (beat_idx_q == 4'd1) && !qual_ok;
        want_ports = ((fld_m.proto == PROTO_TCP) || (fld_m.proto == PROTO_UDP)) && (fld_m.frag[12:0] == 13'd0);
        tuple_done = want_ports ? (last_byte >= l4_off + 8'd3) : (last_byte >= OFF_DA_END);
        load       = parse_beat && !bad_qual && tuple_done;
        drop       = parse_beat && (bad_qual || (s_axis_tlast && !tuple_done));

        state_d = state_q;
        if (parse_beat && (bad_qual || load) && !s_axis_tlast) state_d = ST_DRAIN;
        else if (accept && (state_q == ST_DRAIN) && s_axis_tlast) state_d = ST_PARSE;

        beat_idx_d = beat_idx_q;
        if (accept) begin
            if (s_axis_tlast)            beat_idx_d = 4'd0;
            else if (beat_idx_q != 4'hf) beat_idx_d = beat_idx_q + 4'd1;
        end

        fld_d       = parse_beat ? fld_m : fld_q;
        hdr_d       = load ? {fld_m.proto, fld_m.sa, fld_m.da, (want_ports ? fld_m.ports : 32'd0)} : hdr_q;
        hdr_valid_d = load || (hdr_valid_q && !hdr_ready);
        pkt_cnt_d   = load ? pkt_cnt_q + CNT_WIDTH'(1) : pkt_cnt_q;
        drop_cnt_d  = drop ? drop_cnt_q + CNT_WIDTH'(1) : drop_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_PARSE;
            beat_idx_q  <= 4'd0;
            fld_q       <= '0;
            hdr_q       <= '0;
            hdr_valid_q <= 1'b0;
            pkt_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_idx_q  <= beat_idx_d;
            fld_q       <= fld_d;
            hdr_q       <= hdr_d;
            hdr_valid_q <= hdr_valid_d;
            pkt_cnt_q   <= pkt_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign hdr       = hdr_q;
    assign hdr_valid = hdr_valid_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_header_extractor.sv
// Directed-vector bench for header_extractor: a driver sends frames, expected tuples go into
// a queue, and a monitor pops and compares on every hdr handshake.
module tb_header_extractor;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [103:0]  hdr;
    logic          hdr_valid;
    logic          hdr_ready;
    logic [31:0]   pkt_cnt;
    logic [31:0]   drop_cnt;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            exp_pkt  = 0;
    int            exp_drop = 0;
    logic [103:0]  exp_q[$];
    logic [103:0]  mon_exp;
    logic [7:0]    fb [0:127];

    always #5 clk = ~clk;

    header_extractor dut (
        .clk           (clk),
        .rst           (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .hdr           (hdr),
        .hdr_valid     (hdr_valid),
        .hdr_ready     (hdr_ready),
        .pkt_cnt       (pkt_cnt),
        .drop_cnt      (drop_cnt)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Scoreboard monitor: sampled well after the negedge so all drivers have settled.
    always @(negedge clk) begin
        #2;
        if (rst_n && hdr_valid && hdr_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL hdr_unexpected got=%h want=none", hdr);
            end else begin
                mon_exp = exp_q.pop_front();
                if (hdr !== mon_exp) begin
                    n_fail++;
                    $display("FAIL hdr_tuple got=%h want=%h", hdr, mon_exp);
                end
            end
        end
    end

    task automatic build(input logic [15:0] et, input logic [7:0] vihl, input logic [7:0] proto,
                         input logic [15:0] frag, input logic [31:0] sa, input logic [31:0] da,
                         input logic [15:0] sp, input logic [15:0] dp);
        int l4;
        for (int i = 0; i < 128; i++) fb[i] = 8'(8'hA0 + i);
        l4 = 14 + 4 * int'(vihl[3:0]);
        if (l4 + 3 < 128) begin
            fb[l4] = sp[15:8]; fb[l4+1] = sp[7:0]; fb[l4+2] = dp[15:8]; fb[l4+3] = dp[7:0];
        end
        fb[12] = et[15:8]; fb[13] = et[7:0];
        fb[14] = vihl;
        fb[20] = frag[15:8]; fb[21] = frag[7:0];
        fb[23] = proto;
        for (int j = 0; j < 4; j++) begin
            fb[26+j] = sa[31-8*j -: 8];
            fb[30+j] = da[31-8*j -: 8];
        end
    endtask

    function automatic logic [63:0] beat_data(input int b);
        logic [63:0] d;
        for (int k = 0; k < 8; k++) d[63-8*k -: 8] = fb[8*b+k];
        return d;
    endfunction

    task automatic send_beat(input logic [63:0] data, input logic last);
        logic acc;
        int   guard;
        @(negedge clk);
        s_axis_tdata  = data;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        guard = 0;
        forever begin
            #1;
            acc = s_axis_tready;
            @(posedge clk);
            if (acc) break;
            guard++;
            if (guard > 300) begin
                n_checks++;
                n_fail++;
                $display("FAIL tready_timeout got=stalled want=accept");
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input int nbeats);
        for (int b = 0; b < nbeats; b++) send_beat(beat_data(b), b == nbeats - 1);
    endtask

    task automatic idle_and_check(input string tag);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check({tag, "_pkt_cnt"}, 128'(pkt_cnt), 128'(exp_pkt));
        check({tag, "_drop_cnt"}, 128'(drop_cnt), 128'(exp_drop));
    endtask

    initial begin
        int guard;
        rst_n         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        hdr_ready     = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_hdr", 128'(hdr), 128'd0);
        check("rst_hdr_valid", 128'(hdr_valid), 128'd0);
        check("rst_pkt_cnt", 128'(pkt_cnt), 128'd0);
        check("rst_drop_cnt", 128'(drop_cnt), 128'd0);
        check("rst_tready", 128'(s_axis_tready), 128'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: TCP, IHL=5, DF set; tuple one cycle after beat 4.
        build(16'h0800, 8'h45, 8'h06, 16'h4000, 32'hAC1C0001, 32'h0A000002, 16'h1234, 16'h1D56);
        exp_q.push_back(104'h06_AC1C0001_0A000002_1234_1D56);
        exp_pkt++;
        for (int b = 0; b < 8; b++) begin
            send_beat(beat_data(b), b == 7);
            #1;
            if (b == 3) check("t1_valid_before", 128'(hdr_valid), 128'd0);
            if (b == 4) begin
                check("t1_latency_valid", 128'(hdr_valid), 128'd1);
                check("t1_latency_hdr", 128'(hdr), 128'(104'h06_AC1C0001_0A000002_1234_1D56));
            end
        end
        idle_and_check("t1");

        // 2: UDP, IHL=6, ports straddle the beat 4/5 boundary.
        build(16'h0800, 8'h46, 8'h11, 16'h0000, 32'hC0A80001, 32'hC0A80002, 16'h0035, 16'h8000);
        exp_q.push_back(104'h11_C0A80001_C0A80002_0035_8000);
        exp_pkt++;
        send_frame(8);
        idle_and_check("t2");

        // 3: ARP is dropped, following TCP frame is parsed.
        build(16'h0806, 8'h45, 8'h06, 16'h0000, 32'h01010101, 32'h02020202, 16'h0303, 16'h0404);
        exp_drop++;
        send_frame(8);
        build(16'h0800, 8'h45, 8'h06, 16'h0000, 32'h01020304, 32'h05060708, 16'h0050, 16'hC001);
        exp_q.push_back(104'h06_01020304_05060708_0050_C001);
        exp_pkt++;
        send_frame(8);
        idle_and_check("t3");

        // 4: ICMP and fragmented TCP both emit zero ports.
        build(16'h0800, 8'h45, 8'h01, 16'h0000, 32'h0A0B0C0D, 32'h0E0F1011, 16'h1111, 16'h2222);
        exp_q.push_back(104'h01_0A0B0C0D_0E0F1011_0000_0000);
        exp_pkt++;
        send_frame(8);
        build(16'h0800, 8'h45, 8'h06, 16'h0010, 32'h12345678, 32'h9ABCDEF0, 16'h3333, 16'h4444);
        exp_q.push_back(104'h06_12345678_9ABCDEF0_0000_0000);
        exp_pkt++;
        send_frame(8);
        idle_and_check("t4");

        // 5: truncated frame (tlast on beat 3), then a good frame from byte 0.
        build(16'h0800, 8'h45, 8'h06, 16'h0000, 32'hDEADBEEF, 32'hCAFEF00D, 16'h5555, 16'h6666);
        exp_drop++;
        send_frame(4);
        idle_and_check("t5a");
        check("t5_no_hdr_valid", 128'(hdr_valid), 128'd0);
        build(16'h0800, 8'h45, 8'h06, 16'h0000, 32'hC0000201, 32'hC6336402, 16'h01BB, 16'hD431);
        exp_q.push_back(104'h06_C0000201_C6336402_01BB_D431);
        exp_pkt++;
        send_frame(8);
        idle_and_check("t5b");

        // 6: back-to-back frames with hdr_ready low; second tuple waits for the first handshake.
        @(negedge clk);
        hdr_ready = 1'b0;
        exp_q.push_back(104'h06_0A000001_0A000002_1000_2000);
        exp_q.push_back(104'h11_0A000003_0A000004_3000_4000);
        exp_pkt += 2;
        fork
            begin
                build(16'h0800, 8'h45, 8'h06, 16'h0000, 32'h0A000001, 32'h0A000002, 16'h1000, 16'h2000);
                send_frame(8);
                build(16'h0800, 8'h45, 8'h11, 16'h0000, 32'h0A000003, 32'h0A000004, 16'h3000, 16'h4000);
                send_frame(8);
            end
            begin
                guard = 0;
                forever begin
                    @(negedge clk);
                    #2;
                    if (hdr_valid || guard > 100) break;
                    guard++;
                end
                check("t6_first_valid", 128'(hdr_valid), 128'd1);
                check("t6_tready_stall", 128'(s_axis_tready), 128'd0);
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    #2;
                    check("t6_hold", 128'({hdr_valid, hdr}), 128'({1'b1, 104'h06_0A000001_0A000002_1000_2000}));
                end
                @(negedge clk);
                hdr_ready = 1'b1;
            end
        join
        idle_and_check("t6");

        // 7: IHL=15, ports at bytes 74..77 in beat 9.
        build(16'h0800, 8'h4F, 8'h06, 16'h0000, 32'h11223344, 32'h55667788, 16'hABCD, 16'hEF01);
        exp_q.push_back(104'h06_11223344_55667788_ABCD_EF01);
        exp_pkt++;
        send_frame(11);
        idle_and_check("t7");

        // 8: IHL=4 and version 6 are both disqualified.
        build(16'h0800, 8'h44, 8'h06, 16'h0000, 32'h01010101, 32'h02020202, 16'h0303, 16'h0404);
        exp_drop++;
        send_frame(8);
        build(16'h0800, 8'h65, 8'h06, 16'h0000, 32'h01010101, 32'h02020202, 16'h0303, 16'h0404);
        exp_drop++;
        send_frame(8);
        idle_and_check("t8");

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("queue_drained", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
